// File: rtl/instr_fetch_if.sv
// rtl/instr_fetch_if.sv - instruction memory, decode-stage and redirect signals of the fetch unit
interface instr_fetch_if;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        valid_o;
  logic        ready_i;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        misalign_o;

  modport master (
    output imem_req_o, imem_addr_o, valid_o, inst_o, pc_o, misalign_o,
    input  imem_gnt_i, imem_rvalid_i, imem_rdata_i, ready_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  imem_req_o, imem_addr_o, valid_o, inst_o, pc_o, misalign_o,
    output imem_gnt_i, imem_rvalid_i, imem_rdata_i, ready_i, redirect_i, redirect_pc_i
  );
endinterface

// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - PC, imem request/response tracking, prefetch FIFO and redirect flush
// Optional sticky misaligned-redirect flag under IF_ALIGN_CHECK_EN.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic          clk_i,
  input  logic          rst_i,
  instr_fetch_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fetch_pc;
  logic [CW-1:0] count;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] drop;
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic [AW-1:0] pq_rd, pq_wr;
  logic [31:0]   fifo_pc   [DEPTH];
  logic [31:0]   fifo_inst [DEPTH];
  logic [31:0]   pq_pc     [DEPTH];

  logic [CW:0]   credit_used;
  logic          grant;
  logic          rsp_ok;
  logic          rsp_drop;
  logic          rsp_push;
  logic          pop;
  logic [CW-1:0] outstanding_next;
  logic [31:0]   redirect_target;

  // Buffered plus in-flight words never exceed DEPTH, so every response has a FIFO slot.
  assign credit_used      = {1'b0, count} + {1'b0, outstanding};
  assign bus.imem_req_o   = credit_used < (CW+1)'(DEPTH);
  assign bus.imem_addr_o  = fetch_pc;
  assign grant            = bus.imem_req_o && bus.imem_gnt_i;
  assign rsp_ok           = bus.imem_rvalid_i && (outstanding != '0);
  assign rsp_drop         = rsp_ok && (drop != '0);
  assign rsp_push         = rsp_ok && !rsp_drop;
  assign pop              = bus.valid_o && bus.ready_i;
  assign outstanding_next = outstanding + CW'(grant) - CW'(rsp_ok);
  assign redirect_target  = bus.redirect_pc_i & 32'hFFFF_FFFC;

  assign bus.valid_o = (count != '0);
  assign bus.inst_o  = fifo_inst[rd_ptr];
  assign bus.pc_o    = fifo_pc[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc    <= RESET_PC;
      count       <= '0;
      outstanding <= '0;
      drop        <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
      pq_rd       <= '0;
      pq_wr       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_pc[i]   <= '0;
        fifo_inst[i] <= '0;
        pq_pc[i]     <= '0;
      end
    end else begin
      outstanding <= outstanding_next;
      if (bus.redirect_i) begin
        // Everything still in flight, including a grant taken this cycle, is now stale.
        fetch_pc <= redirect_target;
        drop     <= outstanding_next;
        count    <= '0;
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        pq_rd    <= '0;
        pq_wr    <= '0;
      end else begin
        if (grant) begin
          fetch_pc     <= fetch_pc + 32'd4;
          pq_pc[pq_wr] <= fetch_pc;
          pq_wr        <= pq_wr + 1'b1;
        end
        if (rsp_drop) begin
          drop <= drop - 1'b1;
        end
        if (rsp_push) begin
          fifo_pc[wr_ptr]   <= pq_pc[pq_rd];
          fifo_inst[wr_ptr] <= bus.imem_rdata_i;
          wr_ptr            <= wr_ptr + 1'b1;
          pq_rd             <= pq_rd + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        count <= count + CW'(rsp_push) - CW'(pop);
      end
    end
  end

`ifdef IF_ALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      misalign_q <= 1'b0;
    end else if (bus.redirect_i && (bus.redirect_pc_i[1:0] != 2'b00)) begin
      misalign_q <= 1'b1;
    end
  end

  assign bus.misalign_o = misalign_q;
`else
  assign bus.misalign_o = 1'b0;
`endif
endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - directed bench for instr_fetch with an in-order latency memory model
module tb_instr_fetch;
  logic clk;
  logic rst;
  instr_fetch_if bus();

  instr_fetch #(.RESET_PC(32'h0000_0100), .DEPTH(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

`ifdef IF_ALIGN_CHECK_EN
  localparam bit MIS_EXP = 1'b1;
`else
  localparam bit MIS_EXP = 1'b0;
`endif

  int          checks   = 0;
  int          failures = 0;
  int          lat      = 1;
  bit          gnt_en   = 1'b1;
  int          cyc      = 0;
  logic [31:0] mq_addr [$];
  int          mq_t    [$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory answers each granted address with addr ^ 0xA5A5_0000 after lat cycles, in order.
  initial begin
    bus.imem_gnt_i    = 1'b1;
    bus.imem_rvalid_i = 1'b0;
    bus.imem_rdata_i  = '0;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        mq_addr.delete();
        mq_t.delete();
        bus.imem_rvalid_i = 1'b0;
      end else begin
        bus.imem_rvalid_i = 1'b0;
        if (mq_addr.size() > 0 && (cyc - mq_t[0]) >= lat) begin
          bus.imem_rvalid_i = 1'b1;
          bus.imem_rdata_i  = mq_addr[0] ^ 32'hA5A5_0000;
          void'(mq_addr.pop_front());
          void'(mq_t.pop_front());
        end
        bus.imem_gnt_i = gnt_en;
        if (bus.imem_req_o && gnt_en) begin
          mq_addr.push_back(bus.imem_addr_o);
          mq_t.push_back(cyc);
        end
      end
      cyc++;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_reset;
    rst = 1'b0;
    bus.ready_i = 1'b1;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    gnt_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.valid_o && n < 30);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    bus.ready_i = 1'b1;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    lat = 1;
    repeat (2) @(negedge clk);
    checks++;
    if ({bus.valid_o, bus.inst_o, bus.pc_o, bus.misalign_o} !== {1'b0, 32'h0, 32'h0, 1'b0}) begin
      failures++;
      $display("FAIL reset_outputs: valid=%0b inst=%h pc=%h mis=%0b required 0/0/0/0",
               bus.valid_o, bus.inst_o, bus.pc_o, bus.misalign_o);
    end
    checks++;
    if ({bus.imem_req_o, bus.imem_addr_o} !== {1'b1, 32'h0000_0100}) begin
      failures++;
      $display("FAIL reset_req: req=%0b addr=%h required 1/00000100", bus.imem_req_o, bus.imem_addr_o);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.valid_o, bus.imem_addr_o} !== {1'b0, 32'h0000_0104}) begin
      failures++;
      $display("FAIL first_grant: valid=%0b addr=%h required 0/00000104", bus.valid_o, bus.imem_addr_o);
    end
  endtask

  task automatic test_stream;
    logic [31:0] exp_pc;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      exp_pc = 32'h0000_0100 + 32'(4 * k);
      checks++;
      if ({bus.valid_o, bus.pc_o, bus.inst_o} !== {1'b1, exp_pc, exp_pc ^ 32'hA5A5_0000}) begin
        failures++;
        $display("FAIL stream[%0d]: valid=%0b pc=%h inst=%h required 1/%h/%h",
                 k, bus.valid_o, bus.pc_o, bus.inst_o, exp_pc, exp_pc ^ 32'hA5A5_0000);
      end
    end
  endtask

  task automatic test_backpressure;
    int          bad;
    logic [31:0] exp_pc;
    @(negedge clk);
    bus.ready_i = 1'b0;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (!bus.valid_o || bus.pc_o !== 32'h0000_0120 || bus.inst_o !== 32'hA5A5_0120) bad++;
    end
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL bp_head_stable: unstable_cycles=%0d required 0 (pc=%h)", bad, bus.pc_o);
    end
    checks++;
    if (dut.count !== 3'd4 || bus.imem_req_o !== 1'b0) begin
      failures++;
      $display("FAIL bp_full: count=%0d req=%0b required 4/0", dut.count, bus.imem_req_o);
    end
    bus.ready_i = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      exp_pc = 32'h0000_0120 + 32'(4 * k);
      checks++;
      if ({bus.valid_o, bus.pc_o, bus.inst_o} !== {1'b1, exp_pc, exp_pc ^ 32'hA5A5_0000}) begin
        failures++;
        $display("FAIL bp_release[%0d]: valid=%0b pc=%h inst=%h required 1/%h/%h",
                 k, bus.valid_o, bus.pc_o, bus.inst_o, exp_pc, exp_pc ^ 32'hA5A5_0000);
      end
    end
  endtask

  task automatic test_redirect_inflight;
    int          n;
    logic [31:0] exp_pc;
    lat = 3;
    do_reset();
    repeat (2) @(negedge clk);
    gnt_en = 1'b0;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0400;
    checks++;
    if (dut.outstanding !== 3'd2 || bus.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL rd_setup: outstanding=%0d valid=%0b required 2/0", dut.outstanding, bus.valid_o);
    end
    @(negedge clk);
    bus.redirect_i = 1'b0;
    gnt_en = 1'b1;
    checks++;
    if ({dut.drop, bus.imem_addr_o, bus.valid_o} !== {3'd2, 32'h0000_0400, 1'b0}) begin
      failures++;
      $display("FAIL rd_drop: drop=%0d addr=%h valid=%0b required 2/00000400/0",
               dut.drop, bus.imem_addr_o, bus.valid_o);
    end
    wait_valid(n);
    checks++;
    if (!bus.valid_o || n != 4 || bus.pc_o !== 32'h0000_0400 || bus.inst_o !== 32'hA5A5_0400) begin
      failures++;
      $display("FAIL rd_first: valid=%0b wait=%0d pc=%h inst=%h required 1/4/00000400/a5a50400",
               bus.valid_o, n, bus.pc_o, bus.inst_o);
    end
    for (int k = 1; k < 4; k++) begin
      wait_valid(n);
      exp_pc = 32'h0000_0400 + 32'(4 * k);
      checks++;
      if (!bus.valid_o || bus.pc_o !== exp_pc || bus.inst_o !== (exp_pc ^ 32'hA5A5_0000)) begin
        failures++;
        $display("FAIL rd_next[%0d]: valid=%0b pc=%h inst=%h required 1/%h", k, bus.valid_o, bus.pc_o, bus.inst_o, exp_pc);
      end
    end
  endtask

  task automatic test_simultaneous;
    int n;
    lat = 1;
    do_reset();
    repeat (4) @(negedge clk);
    checks++;
    if ({bus.valid_o, bus.imem_req_o} !== 2'b11) begin
      failures++;
      $display("FAIL sim_setup: valid=%0b req=%0b required 1/1", bus.valid_o, bus.imem_req_o);
    end
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0800;
    @(negedge clk);
    bus.redirect_i = 1'b0;
    checks++;
    if ({bus.valid_o, dut.drop, bus.imem_addr_o} !== {1'b0, 3'd1, 32'h0000_0800}) begin
      failures++;
      $display("FAIL sim_flush: valid=%0b drop=%0d addr=%h required 0/1/00000800",
               bus.valid_o, dut.drop, bus.imem_addr_o);
    end
    wait_valid(n);
    checks++;
    if (!bus.valid_o || n != 2 || bus.pc_o !== 32'h0000_0800 || bus.inst_o !== 32'hA5A5_0800) begin
      failures++;
      $display("FAIL sim_first: valid=%0b wait=%0d pc=%h inst=%h required 1/2/00000800/a5a50800",
               bus.valid_o, n, bus.pc_o, bus.inst_o);
    end
    wait_valid(n);
    checks++;
    if (!bus.valid_o || bus.pc_o !== 32'h0000_0804) begin
      failures++;
      $display("FAIL sim_next: valid=%0b pc=%h required 1/00000804", bus.valid_o, bus.pc_o);
    end
  endtask

  task automatic test_wrap;
    int          n;
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'hFFFF_FFF8;
    @(negedge clk);
    bus.redirect_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      wait_valid(n);
      checks++;
      if (!bus.valid_o || bus.pc_o !== exp_pc[k] || bus.inst_o !== (exp_pc[k] ^ 32'hA5A5_0000)) begin
        failures++;
        $display("FAIL wrap[%0d]: valid=%0b pc=%h inst=%h required 1/%h", k, bus.valid_o, bus.pc_o, bus.inst_o, exp_pc[k]);
      end
    end
  endtask

  task automatic test_misalign;
    int n;
    checks++;
    if (bus.misalign_o !== 1'b0) begin
      failures++;
      $display("FAIL mis_initial: misalign=%0b required 0", bus.misalign_o);
    end
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0203;
    @(negedge clk);
    bus.redirect_i = 1'b0;
    checks++;
    if (bus.misalign_o !== MIS_EXP || bus.imem_addr_o !== 32'h0000_0200) begin
      failures++;
      $display("FAIL mis_set: misalign=%0b addr=%h required %0b/00000200", bus.misalign_o, bus.imem_addr_o, MIS_EXP);
    end
    wait_valid(n);
    checks++;
    if (!bus.valid_o || bus.pc_o !== 32'h0000_0200) begin
      failures++;
      $display("FAIL mis_pc: valid=%0b pc=%h required 1/00000200", bus.valid_o, bus.pc_o);
    end
    bus.redirect_i = 1'b1;
    bus.redirect_pc_i = 32'h0000_0300;
    @(negedge clk);
    bus.redirect_i = 1'b0;
    wait_valid(n);
    checks++;
    if (!bus.valid_o || bus.pc_o !== 32'h0000_0300 || bus.misalign_o !== MIS_EXP) begin
      failures++;
      $display("FAIL mis_sticky: valid=%0b pc=%h misalign=%0b required 1/00000300/%0b",
               bus.valid_o, bus.pc_o, bus.misalign_o, MIS_EXP);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.misalign_o !== 1'b0 || bus.valid_o !== 1'b0) begin
      failures++;
      $display("FAIL mis_reset: misalign=%0b valid=%0b required 0/0", bus.misalign_o, bus.valid_o);
    end
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    bus.ready_i = 1'b1;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_simultaneous();
    test_wrap();
    test_misalign();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
